// File: rtl/vis_pkg.sv
// Shared constants for the visibility receiver: default component width,
// frame-start marker byte, and the serialiser state encoding.
// Latency: n/a (package). Backpressure: n/a.
package vis_pkg;

  localparam int         VIS_ACCUM_DEFAULT  = 32;
  localparam logic [7:0] VIS_HEADER_DEFAULT = 8'hA5;

  typedef logic [1:0] vis_state_t;

  // Legacy-compatible state encoding.
  localparam vis_state_t ST_IDLE = 2'd0;  // waiting for a visibility beat
  localparam vis_state_t ST_HDR0 = 2'd1;  // emitting frame-start marker
  localparam vis_state_t ST_HDR1 = 2'd2;  // emitting frame sequence number
  localparam vis_state_t ST_DATA = 2'd3;  // emitting visibility bytes

endpackage

// File: rtl/vis_receiver.sv
// Purpose: serialises complex visibilities into a framed byte stream (marker, seq, re LSB-first, im LSB-first).
// Latency: first byte valid the cycle after a beat handshake; 2*ACCUM/8+1 cycles per beat, +2 on a frame's first beat.
// Backpressure: holds byte/state while m_ready_i is low; s_ready_o only high when idle and out of reset.
//
// Ports:
//   vis_clock, reset_n            clock, synchronous active-low reset
//   s_valid_i/s_ready_o/s_last_i  visibility beat handshake and end-of-frame flag
//   s_revis_i, s_imvis_i          real / imaginary visibility components
//   m_valid_o/m_ready_i           byte-stream handshake
//   m_data_o, m_last_o            byte-stream data, final byte of frame
//   frame_o                       one-cycle pulse after a frame completes
//   seq_o                         current frame sequence number (wraps at 256)
//   err_len_o                     sticky frame-length error
module vis_receiver
  import vis_pkg::*;
#(
  parameter int         ACCUM  = VIS_ACCUM_DEFAULT,
  parameter int         TOTAL  = 30,
  parameter logic [7:0] HEADER = VIS_HEADER_DEFAULT
) (
  input  logic             vis_clock,
  input  logic             reset_n,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_last_i,
  input  logic [ACCUM-1:0] s_revis_i,
  input  logic [ACCUM-1:0] s_imvis_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic             frame_o,
  output logic [7:0]       seq_o,
  output logic             err_len_o
);

  localparam int NBYTES = 2 * ACCUM / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [IW-1:0] LAST_BYTE = IW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(TOTAL - 1);

  vis_state_t         state_q;
  logic [IW-1:0]      byte_idx_q;
  logic [CW-1:0]      word_cnt_q;
  logic [2*ACCUM-1:0] vis_q;        // {im, re}: re occupies the low bytes so it goes out first
  logic               last_q;
  logic [7:0]         seq_q;
  logic               err_q;
  logic               frame_q;

  logic s_hs;
  logic m_hs;
  logic count_full;
  logic frame_end;
  logic final_byte;

  assign s_ready_o  = reset_n & (state_q == ST_IDLE);
  assign m_valid_o  = (state_q != ST_IDLE);
  assign s_hs       = s_valid_i & s_ready_o;
  assign m_hs       = m_valid_o & m_ready_i;
  assign count_full = (word_cnt_q == LAST_WORD);
  // A beat closes the frame on an explicit last or when the frame is full,
  // whichever comes first; a mismatch between the two is a length error.
  assign frame_end  = last_q | count_full;
  assign final_byte = (state_q == ST_DATA) && (byte_idx_q == LAST_BYTE);

  assign m_last_o   = final_byte & frame_end;
  assign frame_o    = frame_q;
  assign seq_o      = seq_q;
  assign err_len_o  = err_q;

  // Output byte is a pure function of registered state, so it cannot move
  // while the consumer stalls.
  always_comb begin
    m_data_o = 8'h00;
    case (state_q)
      ST_HDR0: m_data_o = HEADER;
      ST_HDR1: m_data_o = seq_q;
      ST_DATA: m_data_o = vis_q[{byte_idx_q, 3'b000} +: 8];
      default: m_data_o = 8'h00;
    endcase
  end

  always_ff @(posedge vis_clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      vis_q      <= '0;
      last_q     <= 1'b0;
      seq_q      <= 8'h00;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_hs) begin
            vis_q      <= {s_imvis_i, s_revis_i};
            last_q     <= s_last_i;
            byte_idx_q <= '0;
            // Only the first beat of a frame carries the header pair.
            state_q    <= (word_cnt_q == '0) ? ST_HDR0 : ST_DATA;
          end
        end
        ST_HDR0: begin
          if (m_hs) state_q <= ST_HDR1;
        end
        ST_HDR1: begin
          if (m_hs) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (m_hs) begin
            if (final_byte) begin
              state_q <= ST_IDLE;
              if (frame_end) begin
                frame_q    <= 1'b1;
                word_cnt_q <= '0;
                seq_q      <= seq_q + 8'd1;
                if (last_q != count_full) err_q <= 1'b1;
              end else begin
                word_cnt_q <= word_cnt_q + 1'b1;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vis_receiver.sv
// Self-checking bench for vis_receiver with TOTAL=4, ACCUM=32.
// Table of frame scenarios plus hand-written sequences for sticky error, seq wrap and mid-frame reset.
// Bytes are collected on handshake at the falling edge and compared against a stream built by the bench.
module tb_vis_receiver;
  import vis_pkg::*;

  localparam int TOTAL = 4;
  localparam int ACCUM = 32;

  logic        vis_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic        s_last_i  = 1'b0;
  logic [31:0] s_revis_i = '0;
  logic [31:0] s_imvis_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [7:0]  m_data_o;
  logic        m_last_o;
  logic        frame_o;
  logic [7:0]  seq_o;
  logic        err_len_o;

  vis_receiver #(.ACCUM(ACCUM), .TOTAL(TOTAL), .HEADER(8'hA5)) dut (
    .vis_clock (vis_clock),
    .reset_n   (reset_n),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_last_i  (s_last_i),
    .s_revis_i (s_revis_i),
    .s_imvis_i (s_imvis_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .frame_o   (frame_o),
    .seq_o     (seq_o),
    .err_len_o (err_len_o)
  );

  always #5 vis_clock = ~vis_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] rx_dat[$];
  logic       rx_last[$];
  int         frame_cnt = 0;
  bit         stall_en  = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat   = '0;
  logic       prev_last  = 1'b0;

  always @(negedge vis_clock) begin
    if (reset_n) begin
      if (frame_o) frame_cnt++;
      if (m_valid_o) check("s_ready_low_while_busy", {31'd0, s_ready_o}, 32'd0);
      if (prev_stall && m_valid_o) begin
        check("stall_data_stable", {24'd0, m_data_o}, {24'd0, prev_dat});
        check("stall_last_stable", {31'd0, m_last_o}, {31'd0, prev_last});
      end
      if (m_valid_o && m_ready_i) begin
        rx_dat.push_back(m_data_o);
        rx_last.push_back(m_last_o);
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_dat   = m_data_o;
      prev_last  = m_last_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Consumer readiness changes just after the active edge.
  initial begin
    forever begin
      @(posedge vis_clock);
      #1;
      m_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- expected stream ----------------
  logic [7:0] exp_dat[$];
  logic       exp_last[$];
  int         mdl_cnt = 0;
  logic [7:0] mdl_seq = 8'h00;

  task automatic model_beat(input logic [31:0] re, input logic [31:0] im, input logic last);
    logic fe;
    fe = last || (mdl_cnt == TOTAL - 1);
    if (mdl_cnt == 0) begin
      exp_dat.push_back(8'hA5);   exp_last.push_back(1'b0);
      exp_dat.push_back(mdl_seq); exp_last.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_dat.push_back(re[8*k +: 8]); exp_last.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_dat.push_back(im[8*k +: 8]); exp_last.push_back(fe && (k == 3));
    end
    if (fe) begin
      mdl_cnt = 0;
      mdl_seq = mdl_seq + 8'd1;
    end else begin
      mdl_cnt++;
    end
  endtask

  task automatic clear_streams();
    rx_dat.delete(); rx_last.delete(); exp_dat.delete(); exp_last.delete();
    frame_cnt = 0;
  endtask

  task automatic compare_streams(input string name);
    int n;
    check({name, "_byte_count"}, rx_dat.size(), exp_dat.size());
    n = (rx_dat.size() < exp_dat.size()) ? rx_dat.size() : exp_dat.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", name, i + 1), {24'd0, rx_dat[i]}, {24'd0, exp_dat[i]});
      check($sformatf("%s_last%0d", name, i + 1), {31'd0, rx_last[i]}, {31'd0, exp_last[i]});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    @(posedge vis_clock); #1;
    reset_n = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0;
    repeat (2) @(posedge vis_clock);
    #1 reset_n = 1'b1;
    mdl_cnt = 0; mdl_seq = 8'h00;
  endtask

  task automatic send_beat(input logic [31:0] re, input logic [31:0] im, input logic last);
    int t;
    t = 0;
    @(negedge vis_clock);
    while (!s_ready_o && t < 200) begin
      @(negedge vis_clock);
      t++;
    end
    if (!s_ready_o) begin
      check("beat_accept_timeout", {31'd0, s_ready_o}, 32'd1);
    end else begin
      s_valid_i = 1'b1; s_revis_i = re; s_imvis_i = im; s_last_i = last;
      @(posedge vis_clock); #1;
      s_valid_i = 1'b0; s_last_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge vis_clock);
    while (!s_ready_o && t < 400) begin
      @(negedge vis_clock);
      t++;
    end
    if (!s_ready_o) check("idle_timeout", {31'd0, s_ready_o}, 32'd1);
    @(negedge vis_clock); #1;
  endtask

  function automatic logic [31:0] beat_re(input bit vary, input int b);
    return vary ? 32'h04030201 + 32'h11111111 * b : 32'h04030201;
  endfunction
  function automatic logic [31:0] beat_im(input bit vary, input int b);
    return vary ? 32'h08070605 + 32'h11111111 * b : 32'h08070605;
  endfunction

  // ---------------- scenario table ----------------
  typedef struct {
    string      name;
    int         nbeats;
    logic [7:0] last_mask;     // bit b set: s_last_i on beat b
    bit         stall;
    bit         vary;
    int         exp_bytes;
    int         exp_last_pos;  // 1-based position of the first m_last_o byte
    int         exp_frames;
    logic       exp_err;
    logic [7:0] exp_seq;
  } row_t;

  row_t rows[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp;
    int nl;
    logic [31:0] re;
    logic [31:0] im;

    rows[0] = '{"frame4",       4, 8'h08, 1'b0, 1'b0, 34, 34, 1, 1'b0, 8'h01};
    rows[1] = '{"frame4_stall", 4, 8'h08, 1'b1, 1'b1, 34, 34, 1, 1'b0, 8'h01};
    rows[2] = '{"early_last",   2, 8'h02, 1'b0, 1'b1, 18, 18, 1, 1'b1, 8'h01};
    rows[3] = '{"no_last",      5, 8'h00, 1'b0, 1'b1, 44, 34, 1, 1'b1, 8'h01};
    rows[4] = '{"no_last_stall",5, 8'h00, 1'b1, 1'b0, 44, 34, 1, 1'b1, 8'h01};
    rows[5] = '{"two_frames",   8, 8'h88, 1'b1, 1'b1, 68, 34, 2, 1'b0, 8'h02};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge vis_clock);
    #1;
    check("rst_s_ready", {31'd0, s_ready_o}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    check("rst_m_last",  {31'd0, m_last_o},  32'd0);
    check("rst_m_data",  {24'd0, m_data_o},  32'd0);
    check("rst_frame",   {31'd0, frame_o},   32'd0);
    check("rst_seq",     {24'd0, seq_o},     32'd0);
    check("rst_err",     {31'd0, err_len_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge vis_clock);
    check("idle_s_ready", {31'd0, s_ready_o}, 32'd1);

    foreach (rows[r]) begin
      apply_reset();
      clear_streams();
      stall_en = rows[r].stall;
      for (int b = 0; b < rows[r].nbeats; b++) begin
        re = beat_re(rows[r].vary, b);
        im = beat_im(rows[r].vary, b);
        model_beat(re, im, rows[r].last_mask[b]);
        send_beat(re, im, rows[r].last_mask[b]);
      end
      wait_idle();
      stall_en = 1'b0;
      check({rows[r].name, "_rx_bytes"}, rx_dat.size(), rows[r].exp_bytes);
      compare_streams(rows[r].name);
      lp = 0; nl = 0;
      foreach (rx_last[i]) begin
        if (rx_last[i]) begin
          nl++;
          if (lp == 0) lp = i + 1;
        end
      end
      check({rows[r].name, "_last_pos"},   lp, rows[r].exp_last_pos);
      check({rows[r].name, "_last_count"}, nl, rows[r].exp_frames);
      check({rows[r].name, "_frame_pulses"}, frame_cnt, rows[r].exp_frames);
      check({rows[r].name, "_err"}, {31'd0, err_len_o}, {31'd0, rows[r].exp_err});
      check({rows[r].name, "_seq"}, {24'd0, seq_o}, {24'd0, rows[r].exp_seq});
    end

    // Early last: error is sticky and the next frame header carries seq 01.
    apply_reset();
    clear_streams();
    send_beat(32'h04030201, 32'h08070605, 1'b0);
    send_beat(32'h04030201, 32'h08070605, 1'b1);
    wait_idle();
    check("sticky_err_set", {31'd0, err_len_o}, 32'd1);
    rx_dat.delete(); rx_last.delete();
    send_beat(32'hDDCCBBAA, 32'h11223344, 1'b0);
    wait_idle();
    check("sticky_err_held", {31'd0, err_len_o}, 32'd1);
    check("next_hdr_count", rx_dat.size(), 10);
    if (rx_dat.size() >= 3) begin
      check("next_hdr_marker", {24'd0, rx_dat[0]}, 32'hA5);
      check("next_hdr_seq",    {24'd0, rx_dat[1]}, 32'h01);
      check("next_first_data", {24'd0, rx_dat[2]}, 32'hAA);
    end

    // 256 well-formed frames: sequence wraps to 00 with no error.
    apply_reset();
    clear_streams();
    for (int f = 0; f < 256; f++) begin
      for (int b = 0; b < 4; b++) send_beat(32'h04030201, 32'h08070605, b == 3);
      if (f == 254) begin
        wait_idle();
        check("seq_before_wrap", {24'd0, seq_o}, 32'hFF);
      end
    end
    wait_idle();
    check("seq_wrapped",   {24'd0, seq_o}, 32'h00);
    check("wrap_err",      {31'd0, err_len_o}, 32'd0);
    check("wrap_frames",   frame_cnt, 256);
    check("wrap_bytes",    rx_dat.size(), 256 * 34);

    // Reset while the fifth byte of the first beat is on the bus.
    apply_reset();
    clear_streams();
    send_beat(32'h04030201, 32'h08070605, 1'b0);
    send_beat(32'h04030201, 32'h08070605, 1'b0);  // completes first beat, queues second
    wait_idle();
    send_beat(32'h04030201, 32'h08070605, 1'b0);
    wait_idle();
    check("pre_rst_seq", {24'd0, seq_o}, 32'h00);
    apply_reset();
    clear_streams();
    send_beat(32'h04030201, 32'h08070605, 1'b0);
    begin
      int t;
      t = 0;
      while (rx_dat.size() < 4 && t < 50) begin
        @(negedge vis_clock); #1;
        t++;
      end
    end
    check("mid_rst_reach_byte4", rx_dat.size(), 4);
    @(posedge vis_clock); #1;
    check("mid_byte5_on_bus", {24'd0, m_data_o}, 32'h03);
    reset_n = 1'b0;
    @(posedge vis_clock); #1;
    check("mid_rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    check("mid_rst_seq",     {24'd0, seq_o},     32'd0);
    check("mid_rst_frame",   {31'd0, frame_o},   32'd0);
    check("mid_rst_s_ready", {31'd0, s_ready_o}, 32'd0);
    reset_n = 1'b1;
    mdl_cnt = 0; mdl_seq = 8'h00;
    clear_streams();
    for (int b = 0; b < 4; b++) begin
      model_beat(32'h04030201, 32'h08070605, b == 3);
      send_beat(32'h04030201, 32'h08070605, b == 3);
    end
    wait_idle();
    if (rx_dat.size() >= 2) begin
      check("post_rst_marker", {24'd0, rx_dat[0]}, 32'hA5);
      check("post_rst_seq",    {24'd0, rx_dat[1]}, 32'h00);
    end
    compare_streams("post_rst");
    check("post_rst_frames", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
